control_sequencer: RTL and testbench

Parametrised multi-cycle control unit for the bus-based core; next generation of the hard-wired fetch/ALU/set-register state logic.
- Decodes the instruction-register contents and drives all bus-side control strobes: PC, SP, MAR, IR, register file, ALU and memory.
- Adds a memory wait-state handshake with timeout, stack push/pop, immediate load, conditional jumps and HALT.
- Generalises data width and register-select width.
- Sits between the IR and every bus-attached datapath block.

---
 rtl/control_sequencer_if.sv | 37 +++
 rtl/control_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Bus-side bundle between the control sequencer and the datapath blocks it steers.
// master = sequencer (drives strobes), slave = datapath/IR/memory side.
interface control_sequencer_if #(
  parameter int DATA_W    = 8,
  parameter int REG_SEL_W = 2
);
  logic [DATA_W-1:0]    instr;
  logic                 flag_zero;
  logic                 flag_carry;
  logic                 mem_ready;

  logic                 pc_oe, pc_inc, pc_load;
  logic                 sp_oe, sp_inc, sp_dec;
  logic                 mar_load, ir_load;
  logic                 mem_rd, mem_wr;
  logic                 reg_we, reg_oe;
  logic [REG_SEL_W-1:0] reg_sel_in, reg_sel_out;
  logic                 alu_en, alu_oe;
  logic [2:0]           alu_mode;
  logic [3:0]           state;
  logic [3:0]           cycle;
  logic                 halted, fault;

  modport master (
    input  instr, flag_zero, flag_carry, mem_ready,
    output pc_oe, pc_inc, pc_load, sp_oe, sp_inc, sp_dec, mar_load, ir_load,
           mem_rd, mem_wr, reg_we, reg_oe, reg_sel_in, reg_sel_out,
           alu_en, alu_oe, alu_mode, state, cycle, halted, fault
  );

  modport slave (
    output instr, flag_zero, flag_carry, mem_ready,
    input  pc_oe, pc_inc, pc_load, sp_oe, sp_inc, sp_dec, mar_load, ir_load,
           mem_rd, mem_wr, reg_we, reg_oe, reg_sel_in, reg_sel_out,
           alu_en, alu_oe, alu_mode, state, cycle, halted, fault
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control unit: fetches, decodes and sequences each instruction,
// driving bus strobes as a decode of the registered state plus mem_ready.
module control_sequencer #(
  parameter int DATA_W    = 8,
  parameter int REG_SEL_W = 2,
  parameter int MAX_WAIT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH_ADDR = 4'd0,
    S_FETCH_INST = 4'd1,
    S_DECODE     = 4'd2,
    S_MOV        = 4'd3,
    S_IMM_ADDR   = 4'd4,
    S_IMM_READ   = 4'd5,
    S_SP_DEC     = 4'd6,
    S_SP_ADDR    = 4'd7,
    S_MEM_WRITE  = 4'd8,
    S_MEM_READ   = 4'd9,
    S_SP_INC     = 4'd10,
    S_ALU_EXEC   = 4'd11,
    S_ALU_STORE  = 4'd12,
    S_HALTED     = 4'd13,
    S_FAULT      = 4'd14
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_PUSH = 4'h3;
  localparam logic [3:0] OP_POP  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_JC   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  state_e               state_q, state_d;
  logic [3:0]           cycle_q, cycle_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [3:0]           op_q, op_d;
  logic [REG_SEL_W-1:0] rd_q, rd_d, rs_q, rs_d;
  logic                 zf_q, zf_d, cf_q, cf_d;

  logic [3:0]           op_in;
  logic [REG_SEL_W-1:0] rd_in, rs_in;
  logic                 timeout, taken;
  logic [WAIT_W-1:0]    wait_sat;

  assign op_in = bus.instr[DATA_W-1 -: 4];
  assign rd_in = bus.instr[2*REG_SEL_W-1:REG_SEL_W];
  assign rs_in = bus.instr[REG_SEL_W-1:0];

  // The counter holds completed wait cycles; this low cycle would be number MAX_WAIT.
  assign timeout  = (MAX_WAIT != 0) && (int'(wait_q) >= MAX_WAIT - 1);
  assign wait_sat = (&wait_q) ? wait_q : wait_q + 1'b1;

  always_comb begin
    taken = 1'b0;
    case (op_q)
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = zf_q;
      OP_JC:   taken = cf_q;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    case (state_q)
      S_FETCH_ADDR: state_d = S_FETCH_INST;
      S_FETCH_INST, S_IMM_READ, S_MEM_WRITE, S_MEM_READ: begin
        if (bus.mem_ready) begin
          case (state_q)
            S_FETCH_INST: state_d = S_DECODE;
            S_MEM_READ:   state_d = S_SP_INC;
            default:      state_d = S_FETCH_ADDR;
          endcase
        end else if (timeout) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_sat;
        end
      end
      S_DECODE: begin
        op_d = op_in;
        rd_d = rd_in;
        rs_d = rs_in;
        zf_d = bus.flag_zero;
        cf_d = bus.flag_carry;
        case (op_in)
          OP_NOP:                      state_d = S_FETCH_ADDR;
          OP_MOV:                      state_d = S_MOV;
          OP_LDI, OP_JMP, OP_JZ, OP_JC: state_d = S_IMM_ADDR;
          OP_PUSH:                     state_d = S_SP_DEC;
          OP_POP:                      state_d = S_SP_ADDR;
          OP_HALT:                     state_d = S_HALTED;
          default:                     state_d = S_ALU_EXEC;
        endcase
      end
      S_MOV:       state_d = S_FETCH_ADDR;
      S_IMM_ADDR:  state_d = S_IMM_READ;
      S_SP_DEC:    state_d = S_SP_ADDR;
      S_SP_ADDR:   state_d = (op_q == OP_PUSH) ? S_MEM_WRITE : S_MEM_READ;
      S_SP_INC:    state_d = S_FETCH_ADDR;
      S_ALU_EXEC:  state_d = S_ALU_STORE;
      S_ALU_STORE: state_d = S_FETCH_ADDR;
      S_HALTED:    state_d = S_HALTED;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_FETCH_ADDR;
    endcase
    cycle_d = (state_d == S_FETCH_ADDR) ? 4'd0 :
              (&cycle_q)                ? cycle_q : cycle_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH_ADDR;
      cycle_q <= '0;
      wait_q  <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
    end
  end

  // Selects and mode are only non-zero alongside their strobe, so idle bus fields stay quiet.
  always_comb begin
    bus.pc_oe       = 1'b0;
    bus.pc_inc      = 1'b0;
    bus.pc_load     = 1'b0;
    bus.sp_oe       = 1'b0;
    bus.sp_inc      = 1'b0;
    bus.sp_dec      = 1'b0;
    bus.mar_load    = 1'b0;
    bus.ir_load     = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.reg_we      = 1'b0;
    bus.reg_oe      = 1'b0;
    bus.reg_sel_in  = '0;
    bus.reg_sel_out = '0;
    bus.alu_en      = 1'b0;
    bus.alu_oe      = 1'b0;
    bus.alu_mode    = 3'd0;
    if (!reset) begin
      case (state_q)
        S_FETCH_ADDR, S_IMM_ADDR: begin
          bus.pc_oe    = 1'b1;
          bus.mar_load = 1'b1;
        end
        S_FETCH_INST: begin
          bus.mem_rd = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_load = 1'b1;
            bus.pc_inc  = 1'b1;
          end
        end
        S_MOV: begin
          bus.reg_oe      = 1'b1;
          bus.reg_sel_out = rs_q;
          bus.reg_we      = 1'b1;
          bus.reg_sel_in  = rd_q;
        end
        S_IMM_READ: begin
          bus.mem_rd = 1'b1;
          if (bus.mem_ready) begin
            if (op_q == OP_LDI) begin
              bus.reg_we     = 1'b1;
              bus.reg_sel_in = rd_q;
              bus.pc_inc     = 1'b1;
            end else if (taken) begin
              bus.pc_load = 1'b1;
            end else begin
              bus.pc_inc = 1'b1;
            end
          end
        end
        S_SP_DEC: bus.sp_dec = 1'b1;
        S_SP_ADDR: begin
          bus.sp_oe    = 1'b1;
          bus.mar_load = 1'b1;
        end
        S_MEM_WRITE: begin
          bus.reg_oe      = 1'b1;
          bus.reg_sel_out = rs_q;
          bus.mem_wr      = 1'b1;
        end
        S_MEM_READ: begin
          bus.mem_rd = 1'b1;
          if (bus.mem_ready) begin
            bus.reg_we     = 1'b1;
            bus.reg_sel_in = rd_q;
          end
        end
        S_SP_INC: bus.sp_inc = 1'b1;
        S_ALU_EXEC: begin
          bus.alu_en   = 1'b1;
          bus.alu_mode = op_q[2:0];
        end
        S_ALU_STORE: begin
          bus.alu_oe     = 1'b1;
          bus.reg_we     = 1'b1;
          bus.reg_sel_in = rd_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.state  = state_q;
  assign bus.cycle  = cycle_q;
  assign bus.halted = (state_q == S_HALTED) || (state_q == S_FAULT);
  assign bus.fault  = (state_q == S_FAULT);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a directed vector table, then per-instruction
// expected traces built from opcode phase lists, driven with random waits.
module tb_control_sequencer;
  localparam int DATA_W = 8, REG_SEL_W = 2, MAX_WAIT = 15;

  localparam logic [13:0] PC_OE  = 14'h0001, PC_INC = 14'h0002, PC_LOAD = 14'h0004;
  localparam logic [13:0] SP_OE  = 14'h0008, SP_INC = 14'h0010, SP_DEC  = 14'h0020;
  localparam logic [13:0] MAR_LD = 14'h0040, IR_LD  = 14'h0080, MEM_RD  = 14'h0100;
  localparam logic [13:0] MEM_WR = 14'h0200, REG_WE = 14'h0400, REG_OE  = 14'h0800;
  localparam logic [13:0] ALU_EN = 14'h1000, ALU_OE = 14'h2000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  control_sequencer_if #(.DATA_W(DATA_W), .REG_SEL_W(REG_SEL_W)) bus ();
  control_sequencer #(.DATA_W(DATA_W), .REG_SEL_W(REG_SEL_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [13:0] act_sb;
  assign act_sb = {bus.alu_oe, bus.alu_en, bus.reg_oe, bus.reg_we, bus.mem_wr, bus.mem_rd,
                   bus.ir_load, bus.mar_load, bus.sp_dec, bus.sp_inc, bus.sp_oe,
                   bus.pc_load, bus.pc_inc, bus.pc_oe};

  typedef struct {
    logic [3:0]  st;
    logic [13:0] sb;
    logic [1:0]  si, so;
    logic [2:0]  am;
    logic        rdy, fz, fc;
  } cyc_t;

  typedef struct {
    logic [7:0]  instr;
    logic        fz, rdy;
    logic [3:0]  st;
    logic [13:0] sb;
    logic [1:0]  si;
    logic [3:0]  cyc;
  } vec_t;

  cyc_t exp_q[$];
  bit   dead;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push_c(logic [3:0] st, logic [13:0] sb, logic [1:0] si, logic [1:0] so,
                                 logic [2:0] am, logic rdy, logic fz, logic fc);
    cyc_t c;
    if (dead) return;
    c.st = st; c.sb = sb; c.si = si; c.so = so; c.am = am; c.rdy = rdy; c.fz = fz; c.fc = fc;
    exp_q.push_back(c);
  endfunction

  // A memory phase: w low-ready cycles then a ready cycle, or a timeout into FAULT.
  function automatic void push_mem(logic [3:0] st, logic [13:0] base, logic [13:0] done,
                                   logic [1:0] si_done, logic [1:0] so_all, int w);
    if (MAX_WAIT != 0 && w >= MAX_WAIT) begin
      for (int i = 0; i < MAX_WAIT; i++) push_c(st, base, 2'd0, so_all, 3'd0, 1'b0, rb(), rb());
      for (int i = 0; i < 4; i++) push_c(4'd14, 14'h0, 2'd0, 2'd0, 3'd0, rb(), rb(), rb());
      dead = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) push_c(st, base, 2'd0, so_all, 3'd0, 1'b0, rb(), rb());
      push_c(st, base | done, si_done, so_all, 3'd0, 1'b1, rb(), rb());
    end
  endfunction

  function automatic void build(logic [7:0] instr, logic fz, logic fc, int w0, int w1);
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic       tk;
    op = instr[7:4]; rd = instr[3:2]; rs = instr[1:0];
    dead = 1'b0;
    exp_q.delete();
    push_c(4'd0, PC_OE | MAR_LD, 2'd0, 2'd0, 3'd0, rb(), rb(), rb());
    push_mem(4'd1, MEM_RD, IR_LD | PC_INC, 2'd0, 2'd0, w0);
    push_c(4'd2, 14'h0, 2'd0, 2'd0, 3'd0, rb(), fz, fc);
    case (op)
      4'h0: ;
      4'h1: push_c(4'd3, REG_OE | REG_WE, rd, rs, 3'd0, rb(), rb(), rb());
      4'h2, 4'h5, 4'h6, 4'h7: begin
        tk = (op == 4'h5) || (op == 4'h6 && fz) || (op == 4'h7 && fc);
        push_c(4'd4, PC_OE | MAR_LD, 2'd0, 2'd0, 3'd0, rb(), rb(), rb());
        if (op == 4'h2) push_mem(4'd5, MEM_RD, REG_WE | PC_INC, rd, 2'd0, w1);
        else            push_mem(4'd5, MEM_RD, tk ? PC_LOAD : PC_INC, 2'd0, 2'd0, w1);
      end
      4'h3: begin
        push_c(4'd6, SP_DEC, 2'd0, 2'd0, 3'd0, rb(), rb(), rb());
        push_c(4'd7, SP_OE | MAR_LD, 2'd0, 2'd0, 3'd0, rb(), rb(), rb());
        push_mem(4'd8, MEM_WR | REG_OE, 14'h0, 2'd0, rs, w1);
      end
      4'h4: begin
        push_c(4'd7, SP_OE | MAR_LD, 2'd0, 2'd0, 3'd0, rb(), rb(), rb());
        push_mem(4'd9, MEM_RD, REG_WE, rd, 2'd0, w1);
        push_c(4'd10, SP_INC, 2'd0, 2'd0, 3'd0, rb(), rb(), rb());
      end
      4'hF: for (int i = 0; i < 5; i++) push_c(4'd13, 14'h0, 2'd0, 2'd0, 3'd0, rb(), rb(), rb());
      default: begin
        push_c(4'd11, ALU_EN, 2'd0, 2'd0, op[2:0], rb(), rb(), rb());
        push_c(4'd12, ALU_OE | REG_WE, rd, 2'd0, 3'd0, rb(), rb(), rb());
      end
    endcase
  endfunction

  task automatic check(input cyc_t c, input logic [3:0] cyc, input string tag);
    logic eh, ef;
    eh = (c.st == 4'd13) || (c.st == 4'd14);
    ef = (c.st == 4'd14);
    vecs++;
    if (bus.state !== c.st || act_sb !== c.sb || bus.reg_sel_in !== c.si ||
        bus.reg_sel_out !== c.so || bus.alu_mode !== c.am || bus.cycle !== cyc ||
        bus.halted !== eh || bus.fault !== ef) begin
      errs++;
      $display("FAIL %s: got st=%0d sb=%h si=%0d so=%0d am=%0d cyc=%0d h=%b f=%b, want st=%0d sb=%h si=%0d so=%0d am=%0d cyc=%0d h=%b f=%b",
               tag, bus.state, act_sb, bus.reg_sel_in, bus.reg_sel_out, bus.alu_mode, bus.cycle,
               bus.halted, bus.fault, c.st, c.sb, c.si, c.so, c.am, cyc, eh, ef);
    end
  endtask

  // Entered and left at a negedge; instr is scrambled after DECODE to prove it was latched.
  task automatic run(input logic [7:0] instr, input int limit, input string name);
    bit past_dec = 1'b0;
    for (int i = 0; i < exp_q.size() && i < limit; i++) begin
      bus.instr      = past_dec ? 8'($urandom) : instr;
      bus.mem_ready  = exp_q[i].rdy;
      bus.flag_zero  = exp_q[i].fz;
      bus.flag_carry = exp_q[i].fc;
      if (exp_q[i].st == 4'd2) past_dec = 1'b1;
      #1;
      check(exp_q[i], (i > 15) ? 4'd15 : 4'(i), $sformatf("%s[%0d]", name, i));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    vecs++;
    if (act_sb !== 14'h0 || bus.reg_sel_in !== 2'd0 || bus.reg_sel_out !== 2'd0 || bus.alu_mode !== 3'd0) begin
      errs++;
      $display("FAIL reset_strobes: got sb=%h si=%0d so=%0d am=%0d, want all 0",
               act_sb, bus.reg_sel_in, bus.reg_sel_out, bus.alu_mode);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    #2;
    if ($countones({bus.pc_oe, bus.sp_oe, bus.reg_oe, bus.alu_oe, bus.mem_rd}) > 1) begin
      errs++;
      $display("FAIL bus_exclusive: got pc_oe=%b sp_oe=%b reg_oe=%b alu_oe=%b mem_rd=%b, want at most one",
               bus.pc_oe, bus.sp_oe, bus.reg_oe, bus.alu_oe, bus.mem_rd);
    end
  end

  function automatic vec_t mk(logic [7:0] instr, logic fz, logic rdy, logic [3:0] st,
                              logic [13:0] sb, logic [1:0] si, logic [3:0] cyc);
    vec_t v;
    v.instr = instr; v.fz = fz; v.rdy = rdy; v.st = st; v.sb = sb; v.si = si; v.cyc = cyc;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    logic [7:0] ins;
    int         w0, w1;
    cyc_t       c;

    tbl[0]  = mk(8'h00, 1'b0, 1'b1, 4'd0, PC_OE | MAR_LD,          2'd0, 4'd0);
    tbl[1]  = mk(8'h00, 1'b0, 1'b1, 4'd1, MEM_RD | IR_LD | PC_INC, 2'd0, 4'd1);
    tbl[2]  = mk(8'h00, 1'b0, 1'b1, 4'd2, 14'h0,                   2'd0, 4'd2);
    tbl[3]  = mk(8'h28, 1'b0, 1'b1, 4'd0, PC_OE | MAR_LD,          2'd0, 4'd0);
    tbl[4]  = mk(8'h28, 1'b0, 1'b1, 4'd1, MEM_RD | IR_LD | PC_INC, 2'd0, 4'd1);
    tbl[5]  = mk(8'h28, 1'b0, 1'b1, 4'd2, 14'h0,                   2'd0, 4'd2);
    tbl[6]  = mk(8'h28, 1'b0, 1'b1, 4'd4, PC_OE | MAR_LD,          2'd0, 4'd3);
    tbl[7]  = mk(8'h28, 1'b0, 1'b0, 4'd5, MEM_RD,                  2'd0, 4'd4);
    tbl[8]  = mk(8'h28, 1'b0, 1'b0, 4'd5, MEM_RD,                  2'd0, 4'd5);
    tbl[9]  = mk(8'h28, 1'b0, 1'b1, 4'd5, MEM_RD | REG_WE | PC_INC, 2'd2, 4'd6);
    tbl[10] = mk(8'h60, 1'b1, 1'b1, 4'd0, PC_OE | MAR_LD,          2'd0, 4'd0);
    tbl[11] = mk(8'h60, 1'b1, 1'b1, 4'd1, MEM_RD | IR_LD | PC_INC, 2'd0, 4'd1);
    tbl[12] = mk(8'h60, 1'b1, 1'b1, 4'd2, 14'h0,                   2'd0, 4'd2);
    tbl[13] = mk(8'h60, 1'b0, 1'b1, 4'd4, PC_OE | MAR_LD,          2'd0, 4'd3);
    tbl[14] = mk(8'h60, 1'b0, 1'b1, 4'd5, MEM_RD | PC_LOAD,        2'd0, 4'd4);
    tbl[15] = mk(8'h60, 1'b0, 1'b1, 4'd0, PC_OE | MAR_LD,          2'd0, 4'd0);
    tbl[16] = mk(8'h60, 1'b0, 1'b1, 4'd1, MEM_RD | IR_LD | PC_INC, 2'd0, 4'd1);
    tbl[17] = mk(8'h60, 1'b0, 1'b1, 4'd2, 14'h0,                   2'd0, 4'd2);
    tbl[18] = mk(8'h60, 1'b1, 1'b1, 4'd4, PC_OE | MAR_LD,          2'd0, 4'd3);
    tbl[19] = mk(8'h60, 1'b1, 1'b1, 4'd5, MEM_RD | PC_INC,         2'd0, 4'd4);

    bus.instr = 8'h00; bus.flag_zero = 1'b0; bus.flag_carry = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      bus.instr = tbl[i].instr; bus.flag_zero = tbl[i].fz; bus.flag_carry = 1'b0;
      bus.mem_ready = tbl[i].rdy;
      #1;
      c.st = tbl[i].st; c.sb = tbl[i].sb; c.si = tbl[i].si; c.so = 2'd0; c.am = 3'd0;
      c.rdy = tbl[i].rdy; c.fz = tbl[i].fz; c.fc = 1'b0;
      check(c, tbl[i].cyc, $sformatf("tbl[%0d]", i));
      @(negedge clk);
    end

    build(8'h31, 1'b0, 1'b0, 0, 2);  run(8'h31, 1000, "push_r1");
    build(8'h4C, 1'b0, 1'b0, 1, 1);  run(8'h4C, 1000, "pop_r3");
    build(8'h1B, 1'b0, 1'b0, 0, 0);  run(8'h1B, 1000, "mov_r2_r3");
    build(8'h70, 1'b0, 1'b1, 0, 0);  run(8'h70, 1000, "jc_taken");
    build(8'h50, 1'b0, 1'b0, 0, 3);  run(8'h50, 1000, "jmp");
    build(8'h00, 1'b0, 1'b0, MAX_WAIT - 1, 0); run(8'h00, 1000, "fetch_wait_limit_ok");
    build(8'hB4, 1'b0, 1'b0, 0, 0);  run(8'hB4, 1000, "alu_b_r1");
    build(8'hF0, 1'b0, 1'b0, 0, 0);  run(8'hF0, 1000, "halt");
    do_reset();

    build(8'h00, 1'b0, 1'b0, MAX_WAIT, 0); run(8'h00, 1000, "fetch_timeout");
    do_reset();
    build(8'h32, 1'b0, 1'b0, 0, MAX_WAIT); run(8'h32, 1000, "push_timeout");
    do_reset();

    build(8'h28, 1'b0, 1'b0, 0, 10); run(8'h28, 8, "ldi_mid_wait");
    do_reset();

    for (int n = 0; n < 150; n++) begin
      ins = {4'($urandom_range(0, 14)), 4'($urandom)};
      w0  = $urandom_range(0, 2);
      w1  = ($urandom_range(0, 7) == 0) ? $urandom_range(10, MAX_WAIT - 1) : $urandom_range(0, 3);
      build(ins, rb(), rb(), w0, w1);
      run(ins, 1000, $sformatf("rnd%0d_%h", n, ins));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
